m68k_bus_arbiter: RTL



---
 rtl/m68k_arb_pkg.sv | 14 +
 rtl/rr_picker.sv | 30 +++
 rtl/m68k_bus_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/m68k_arb_pkg.sv
// Shared widths and state encoding for the 68000 bus arbiter.
package m68k_arb_pkg;

  localparam int unsigned HOLD_W  = 16;
  localparam int unsigned GUARD_W = 4;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t StIdle    = 2'd0;
  localparam arb_state_t StRequest = 2'd1;
  localparam arb_state_t StOwn     = 2'd2;
  localparam arb_state_t StRelease = 2'd3;

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: first set request at or above ptr, wrapping to bit 0.
module rr_picker #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic [IDX_W-1:0]   winner_idx
);

  logic        found;
  int unsigned cand;

  always_comb begin
    winner     = '0;
    winner_idx = '0;
    found      = 1'b0;
    cand       = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = (32'(ptr) + i) % NUM_REQ;
      if (!found && req[cand]) begin
        winner[cand] = 1'b1;
        winner_idx   = IDX_W'(cand);
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/m68k_bus_arbiter.sv
// BR/BG/BGACK handshake toward the 68000 plus round-robin grant to secondary masters.
module m68k_bus_arbiter
  import m68k_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 2,
  parameter int unsigned MAX_HOLD = 256,
  parameter int unsigned GUARD    = 1
) (
  input  logic               CLK_24M,
  input  logic               RESET,
  input  logic               M68K_CLKEN,
  input  logic               nAS,
  input  logic               nBG,
  output logic               nBR,
  output logic               nBGACK,
  input  logic [NUM_REQ-1:0] REQ,
  output logic [NUM_REQ-1:0] GNT,
  output logic               BUS_OWNED
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [HOLD_W-1:0]  HoldLast  = HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  localparam logic [GUARD_W-1:0] GuardLast = GUARD_W'(GUARD - 1);
  localparam logic [IdxW-1:0]    IdxLast   = IdxW'(NUM_REQ - 1);

  arb_state_t          state_q, state_d;
  logic [IdxW-1:0]     ptr_q, ptr_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [GUARD_W-1:0]  guard_q, guard_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic                nbr_q, nbr_d;
  logic                nbgack_q, nbgack_d;
  logic                owned_q, owned_d;

  logic [NUM_REQ-1:0]  pick_onehot;
  logic [IdxW-1:0]     pick_idx;
  logic                winner_done;
  logic                hold_expired;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IdxW)
  ) u_picker (
    .req        (REQ),
    .ptr        (ptr_q),
    .winner     (pick_onehot),
    .winner_idx (pick_idx)
  );

  // gnt_q holds the winner one-hot for the whole tenure, so it doubles as the winner mask.
  assign winner_done  = ~|(REQ & gnt_q);
  assign hold_expired = (MAX_HOLD != 0) && (hold_q == HoldLast);

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    hold_d   = hold_q;
    guard_d  = guard_q;
    gnt_d    = gnt_q;
    nbr_d    = nbr_q;
    nbgack_d = nbgack_q;
    owned_d  = owned_q;
    case (state_q)
      StIdle: begin
        if (|REQ) begin
          state_d = StRequest;
          nbr_d   = 1'b0;
        end
      end
      StRequest: begin
        if (REQ == '0) begin
          state_d = StIdle;
          nbr_d   = 1'b1;
        end else if (!nBG && nAS) begin
          state_d  = StOwn;
          nbr_d    = 1'b1;
          nbgack_d = 1'b0;
          owned_d  = 1'b1;
          gnt_d    = pick_onehot;
          ptr_d    = (pick_idx == IdxLast) ? '0 : pick_idx + IdxW'(1);
          hold_d   = '0;
        end
      end
      StOwn: begin
        if (hold_q != '1) hold_d = hold_q + HOLD_W'(1);
        if (winner_done || hold_expired) begin
          state_d = StRelease;
          gnt_d   = '0;
          guard_d = '0;
        end
      end
      StRelease: begin
        if (guard_q == GuardLast) begin
          state_d  = StIdle;
          nbgack_d = 1'b1;
          owned_d  = 1'b0;
        end else begin
          guard_d = guard_q + GUARD_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK_24M) begin
    if (RESET) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      hold_q   <= '0;
      guard_q  <= '0;
      gnt_q    <= '0;
      nbr_q    <= 1'b1;
      nbgack_q <= 1'b1;
      owned_q  <= 1'b0;
    end else if (M68K_CLKEN) begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      hold_q   <= hold_d;
      guard_q  <= guard_d;
      gnt_q    <= gnt_d;
      nbr_q    <= nbr_d;
      nbgack_q <= nbgack_d;
      owned_q  <= owned_d;
    end
  end

  assign nBR       = nbr_q;
  assign nBGACK    = nbgack_q;
  assign GNT       = gnt_q;
  assign BUS_OWNED = owned_q;

endmodule
